// File: rtl/moravec_pkg.sv
// Shared constants and types for the Moravec corner-FF window driver.
// The neighbour walk order and the FSM encoding live here so every user agrees on them.
package moravec_pkg;

   localparam int PIX_W   = 8;
   localparam int E_W     = 14;
   localparam int N_NEIGH = 8;

   localparam logic [E_W-1:0] E_INIT = '1;

   // Row-major 3x3 positions visited in order; the centre (4) is never a target.
   localparam logic [3:0] NEIGH_IDX [N_NEIGH] = '{
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8
   };

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      REQ  = 3'd2,
      REL  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/moravec_window_driver.sv
// Initiator for the Moravec min-SSD flip-flop: walks the 8 neighbours of one 3x3 window
// through a 4-phase start/Q handshake, chaining Eout back into inE, and reports the minimum.
module moravec_window_driver #(
   parameter int PIX_W   = moravec_pkg::PIX_W,
   parameter int E_W     = moravec_pkg::E_W,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               win_valid,
   output logic               win_ready,
   input  logic [9*PIX_W-1:0] win_pix,
   input  logic [E_W-1:0]     threshold,
   output logic               ff_start,
   output logic [PIX_W-1:0]   ff_center,
   output logic [PIX_W-1:0]   ff_target,
   output logic [E_W-1:0]     ff_e,
   input  logic               ff_q,
   input  logic [E_W-1:0]     ff_eout,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [E_W-1:0]     res_min_e,
   output logic               res_corner,
   output logic               res_error
);
   import moravec_pkg::*;

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [E_W-1:0]  E_START  = {E_W{1'b1}};
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [2:0]      IDX_LAST = 3'd7;

   state_t           state;
   state_t           state_nxt;
   logic [PIX_W-1:0] pix_q [9];
   logic [E_W-1:0]   thr_q;
   logic [E_W-1:0]   e_acc;
   logic [2:0]       idx;
   logic             err_q;
   logic [TW-1:0]    tmo_cnt;

   logic             accept;
   logic             waiting;
   logic             tmo_hit;
   logic             tmo_fire;

   assign accept  = (state == IDLE) && win_valid;
   assign waiting = (state == SYNC) || (state == REQ) || (state == REL);
   assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

   // Handshake progress always wins over a timeout expiring in the same cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_nxt = state;
      tmo_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) state_nxt = SYNC;
         end
         SYNC: begin
            if (!ff_q) begin
               state_nxt = REQ;
            end else if (tmo_hit) begin
               state_nxt = DONE;
               tmo_fire  = 1'b1;
            end
         end
         REQ: begin
            if (ff_q) begin
               state_nxt = REL;
            end else if (tmo_hit) begin
               state_nxt = DONE;
               tmo_fire  = 1'b1;
            end
         end
         REL: begin
            if (!ff_q) begin
               state_nxt = (idx == IDX_LAST) ? DONE : REQ;
            end else if (tmo_hit) begin
               state_nxt = DONE;
               tmo_fire  = 1'b1;
            end
         end
         DONE: begin
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         // NOTE: the pixel array is reset because it drives ff_center/ff_target directly,
         // which must read zero while in reset.
         for (int k = 0; k < 9; k++) pix_q[k] <= '0;
         thr_q   <= '0;
         e_acc   <= '0;
         idx     <= '0;
         err_q   <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
         state <= state_nxt;

         if ((state_nxt != state) || !waiting) tmo_cnt <= '0;
         else                                  tmo_cnt <= tmo_cnt + 1'b1;

         if (accept) begin
            for (int k = 0; k < 9; k++) pix_q[k] <= win_pix[k*PIX_W +: PIX_W];
            thr_q <= threshold;
            e_acc <= E_START;
            idx   <= '0;
            err_q <= 1'b0;
         end

         if ((state == REQ) && ff_q) e_acc <= ff_eout;

         if ((state == REL) && !ff_q && (idx != IDX_LAST)) idx <= idx + 3'd1;

         if (tmo_fire) err_q <= 1'b1;
      end
   end

   // FF inputs are straight from registers, so they stay stable for the whole request phase.
   assign win_ready  = (state == IDLE) && !rst;
   assign ff_start   = (state == REQ);
   assign ff_center  = pix_q[4];
   assign ff_target  = pix_q[NEIGH_IDX[idx]];
   assign ff_e       = e_acc;

   assign res_valid  = (state == DONE);
   assign res_min_e  = res_valid ? e_acc : '0;
   assign res_corner = res_valid && (e_acc > thr_q);
   assign res_error  = res_valid && err_q;

endmodule

// File: tb/tb_moravec_window_driver.sv
// Self-checking bench for moravec_window_driver with a behavioural Moravec FF responder
// that acts on alternate clock edges, plus a stuck-low stub mode for the timeout path.
module tb_moravec_window_driver;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        win_valid = 1'b0;
   logic        win_ready;
   logic [71:0] win_pix = '0;
   logic [13:0] threshold = '0;
   logic        ff_start;
   logic [7:0]  ff_center;
   logic [7:0]  ff_target;
   logic [13:0] ff_e;
   logic        ff_q;
   logic [13:0] ff_eout;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [13:0] res_min_e;
   logic        res_corner;
   logic        res_error;

   logic        stub_mode = 1'b0;
   logic        m_phase = 1'b0;
   logic        m_q = 1'b0;
   logic [13:0] m_eout = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   moravec_window_driver #(.PIX_W(8), .E_W(14), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .win_valid(win_valid), .win_ready(win_ready), .win_pix(win_pix), .threshold(threshold),
      .ff_start(ff_start), .ff_center(ff_center), .ff_target(ff_target), .ff_e(ff_e),
      .ff_q(ff_q), .ff_eout(ff_eout),
      .res_valid(res_valid), .res_ready(res_ready), .res_min_e(res_min_e),
      .res_corner(res_corner), .res_error(res_error)
   );

   assign ff_q    = stub_mode ? 1'b0 : m_q;
   assign ff_eout = m_eout;

   function automatic logic [13:0] ff_min(input logic [13:0] e, input logic [7:0] c,
                                          input logic [7:0] t);
      int d;
      int sq;
      d  = int'(c) - int'(t);
      sq = d * d;
      return (sq < int'(e)) ? sq[13:0] : e;
   endfunction

   // Moravec FF responder: no reset, only acts on every other rising edge.
   always @(posedge clk) begin
      m_phase <= ~m_phase;
      if (m_phase) begin
         if (ff_start && !m_q) begin
            m_eout <= ff_min(ff_e, ff_center, ff_target);
            m_q    <= 1'b1;
         end else if (!ff_start && m_q) begin
            m_q <= 1'b0;
         end
      end
   end

   // Reference: minimum over the 8 neighbours of the squared difference, capped at 3FFF.
   function automatic logic [13:0] ref_min(input logic [71:0] w);
      int c;
      int best;
      int d;
      c    = int'(w[32 +: 8]);
      best = 16383;
      for (int k = 0; k < 9; k++) begin
         if (k != 4) begin
            d = c - int'(w[k*8 +: 8]);
            if (d * d < best) best = d * d;
         end
      end
      return best[13:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents a window and returns at the negedge just after the accepting edge.
   task automatic offer(input string tag, input logic [71:0] w, input logic [13:0] thr);
      bit ok = 1'b0;
      win_pix   = w;
      threshold = thr;
      win_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (win_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_accept"}, ok, 1);
      @(negedge clk);
      win_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      while (!res_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic collect(input string tag, input logic [71:0] w, input logic [13:0] thr,
                          input int delay, input bit chk_lat);
      int          lat;
      logic [13:0] exp_e;
      wait_res(lat);
      exp_e = ref_min(w);
      check({tag, "_valid"}, res_valid, 1);
      if (chk_lat) check({tag, "_latency_le_36"}, lat <= 36, 1);
      check({tag, "_min_e"}, res_min_e, exp_e);
      check({tag, "_corner"}, res_corner, exp_e > thr);
      check({tag, "_error"}, res_error, 0);
      repeat (delay) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_drop"}, res_valid, 0);
   endtask

   initial begin
      logic [71:0] w_flat;
      logic [71:0] w2;
      logic [71:0] w6;
      logic [71:0] wr;
      logic [13:0] thr;
      logic [13:0] e_r;
      int          lat;
      int          start_cycles;
      bit          found;

      w_flat = {9{8'd50}};
      w2     = {8'd80, 8'd70, 8'd60, 8'd50, 8'd10, 8'd40, 8'd30, 8'd20, 8'd13};
      w6     = {8'd180, 8'd170, 8'd160, 8'd150, 8'd100, 8'd140, 8'd130, 8'd120, 8'd110};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_win_ready", win_ready, 0);
      check("rst_ff_start", ff_start, 0);
      check("rst_ff_e", ff_e, 0);
      check("rst_ff_center", ff_center, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_min_e", res_min_e, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_win_ready", win_ready, 1);

      // 1: flat window
      offer("t1", w_flat, 14'd0);
      collect("t1", w_flat, 14'd0, 0, 1);
      check("t1_ref_is_zero", ref_min(w_flat), 0);

      // 2 and 3: graded neighbours, strict threshold compare
      offer("t2", w2, 14'd5);
      collect("t2", w2, 14'd5, 1, 1);
      offer("t3", w2, 14'd9);
      collect("t3", w2, 14'd9, 0, 1);

      // 4: result held under backpressure, new window waits, then back-to-back accept
      offer("t4", w2, 14'd5);
      wait_res(lat);
      check("t4_valid", res_valid, 1);
      win_pix   = w_flat;
      threshold = 14'd0;
      win_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_hold_valid", res_valid, 1);
         check("t4_hold_min_e", res_min_e, 14'd9);
         check("t4_hold_corner", res_corner, 1);
         check("t4_hold_not_ready", win_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("t4_drop", res_valid, 0);
      check("t4_idle_ready", win_ready, 1);
      @(negedge clk);
      check("t4_b2b_accepted", win_ready, 0);
      win_valid = 1'b0;
      collect("t4_next", w_flat, 14'd0, 0, 1);

      // 5: stuck-low acknowledge times out in REQ
      stub_mode = 1'b1;
      offer("t5", w2, 14'd100);
      start_cycles = 0;
      lat = 0;
      while (!res_valid && lat < 400) begin
         if (ff_start) start_cycles++;
         @(negedge clk);
         lat++;
      end
      check("t5_valid", res_valid, 1);
      check("t5_req_cycles", start_cycles, TIMEOUT);
      check("t5_error", res_error, 1);
      check("t5_min_e", res_min_e, 14'h3FFF);
      check("t5_corner", res_corner, 1);
      check("t5_start_low", ff_start, 0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("t5_drop", res_valid, 0);
      stub_mode = 1'b0;
      offer("t5_after", w2, 14'd5);
      collect("t5_after", w2, 14'd5, 0, 0);

      // Randomized windows against the reference model
      for (int n = 0; n < 24; n++) begin
         int base;
         base = int'($urandom_range(0, 200));
         for (int k = 0; k < 9; k++) wr[k*8 +: 8] = 8'(base + int'($urandom_range(0, 55)));
         e_r = ref_min(wr);
         case ($urandom_range(0, 3))
            0:       thr = (e_r == 0) ? 14'd0 : e_r - 14'd1;
            1:       thr = e_r;
            2:       thr = 14'($urandom);
            default: thr = 14'h3FFF;
         endcase
         offer("rnd", wr, thr);
         collect("rnd", wr, thr, int'($urandom_range(0, 3)), 1);
      end

      // 6: reset while idx 3 is being acknowledged, then recover via SYNC
      offer("t6", w6, 14'd0);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ff_start && ff_q && (ff_target == w6[31:24])) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t6_reach_req3", found, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_start", ff_start, 0);
      check("t6_rst_valid", res_valid, 0);
      check("t6_rst_ff_e", ff_e, 0);
      check("t6_rst_win_ready", win_ready, 0);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_idle_ready", win_ready, 1);
      offer("t6_after", w2, 14'd8);
      collect("t6_after", w2, 14'd8, 0, 0);
      offer("t6_final", w6, 14'd50);
      collect("t6_final", w6, 14'd50, 2, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation did not complete");
   end

endmodule
